conc_obs_recorder: RTL and testbench

Observation recorder sitting directly downstream of the concolic top-under-test. Each stimulus step it samples the design output. When the stimulus word's observation bit is set, it stores the sample with the current step number into a trace buffer. A valid/ready port lets the harness or a host drain the buffer.

---
 rtl/conc_pkg.sv | 21 ++
 rtl/conc_trace_fifo.sv | 87 ++++++++
 rtl/conc_obs_recorder.sv | 139 +++++++++++++
 tb/tb_conc_obs_recorder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/conc_pkg.sv
// Shared types for the concolic observation recorder.
// Optional feature macro: CONC_REC_OVERWRITE_EN (see conc_trace_fifo).
package conc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } conc_rec_state_t;

    localparam int CONC_DROP_W = 16;
    localparam int CONC_PC_W   = 32;
    localparam int CONC_DATA_W = 1;

    // Default-width view of one trace entry; the fifo stores {pc, data}.
    typedef struct packed {
        logic [CONC_PC_W-1:0]   pc;
        logic [CONC_DATA_W-1:0] data;
    } conc_trace_t;

endpackage

// File: rtl/conc_trace_fifo.sv
// Register-array circular trace buffer with occupancy count.
// CONC_REC_OVERWRITE_EN: a write into a full buffer replaces the oldest entry.
module conc_trace_fifo
    import conc_pkg::*;
#(
    parameter int W     = CONC_PC_W + CONC_DATA_W,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clr,
    input  logic                     i_wr_en,
    input  logic [W-1:0]             i_wr_data,
    input  logic                     i_rd_en,
    output logic [W-1:0]             o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full,
    output logic                     o_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_ovf;
    logic w_write;
    logic w_adv_rd;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = i_rd_en && !w_empty;
    assign w_ovf   = i_wr_en && w_full && !w_pop;

`ifdef CONC_REC_OVERWRITE_EN
    assign w_write  = i_wr_en;
    assign w_adv_rd = w_pop || w_ovf;
`else
    assign w_write  = i_wr_en && !w_ovf;
    assign w_adv_rd = w_pop;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_adv_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_write && !w_adv_rd) begin
                r_count <= r_count + CW'(1);
            end else if (!w_write && w_adv_rd) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge i_clk) begin
        if (w_write && !i_clr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_empty   = w_empty;
    assign o_full    = w_full;
    assign o_ovf     = w_ovf;

endmodule

// File: rtl/conc_obs_recorder.sv
// Observation recorder: step counting FSM, capture qualification, drop count.
// CONC_REC_OVERWRITE_EN selects overwrite-oldest on a full trace buffer.
module conc_obs_recorder
    import conc_pkg::*;
#(
    parameter int DATA_W = 1,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   flush,
    input  logic [PC_W-1:0]        max_steps,
    input  logic                   step,
    input  logic                   obs,
    input  logic [DATA_W-1:0]      data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [PC_W-1:0]        rd_pc,
    output logic [DATA_W-1:0]      rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [CONC_DROP_W-1:0] drop_cnt
);

    conc_rec_state_t r_state;
    conc_rec_state_t w_state_nxt;

    logic [PC_W-1:0]        r_pc;
    logic [PC_W-1:0]        r_max;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_overflow;
    logic [CONC_DROP_W-1:0] r_drop;

    logic [PC_W-1:0]        w_pc_inc;
    logic                   w_run;
    logic                   w_cap;
    logic                   w_load;
    logic                   w_rd_en;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_ovf;
    logic [PC_W+DATA_W-1:0] w_head;

    assign w_run    = (r_state == ST_RUN);
    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_cap    = w_run && step && obs && !flush;
    assign w_load   = start && (r_state != ST_RUN) && !flush;
    assign w_rd_en  = rd_ready && !flush;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (step && (r_max != '0) && (w_pc_inc == r_max)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: if (start) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_RUN);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc  <= '0;
            r_max <= '0;
        end else if (flush) begin
            r_pc  <= '0;
        end else if (w_load) begin
            r_pc  <= '0;
            r_max <= max_steps;
        end else if (w_run && step) begin
            r_pc  <= w_pc_inc;
        end
    end

    // Drops are counted in both modes; the count saturates rather than wraps.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
            r_drop     <= '0;
        end else if (flush) begin
            r_overflow <= 1'b0;
            r_drop     <= '0;
        end else if (w_ovf) begin
            r_overflow <= 1'b1;
            if (r_drop != '1) begin
                r_drop <= r_drop + CONC_DROP_W'(1);
            end
        end
    end

    conc_trace_fifo #(
        .W     (PC_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (clock),
        .i_rst_n   (reset),
        .i_clr     (flush),
        .i_wr_en   (w_cap),
        .i_wr_data ({w_pc_inc, data}),
        .i_rd_en   (w_rd_en),
        .o_rd_data (w_head),
        .o_count   (count),
        .o_empty   (w_empty),
        .o_full    (w_full),
        .o_ovf     (w_ovf)
    );

    assign rd_valid = !w_empty;
    assign rd_pc    = w_head[PC_W+DATA_W-1:DATA_W];
    assign rd_data  = w_head[DATA_W-1:0];
    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop;

endmodule

// File: tb/tb_conc_obs_recorder.sv
// Directed bench for conc_obs_recorder (DEPTH=4).
// Expectations follow CONC_REC_OVERWRITE_EN when it is defined.
module tb_conc_obs_recorder;

    localparam int DATA_W = 1;
    localparam int PC_W   = 32;
    localparam int DEPTH  = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              flush = 1'b0;
    logic [PC_W-1:0]   max_steps = '0;
    logic              step = 1'b0;
    logic              obs = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic              rd_valid;
    logic              rd_ready = 1'b0;
    logic [PC_W-1:0]   rd_pc;
    logic [DATA_W-1:0] rd_data;
    logic [2:0]        count;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [15:0]       drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    conc_obs_recorder #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .flush     (flush),
        .max_steps (max_steps),
        .step      (step),
        .obs       (obs),
        .data      (data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_pc     (rd_pc),
        .rd_data   (rd_data),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_step(input logic o, input logic d);
        step = 1'b1;
        obs  = o;
        data = d;
        tick();
        step = 1'b0;
        obs  = 1'b0;
    endtask

    task automatic do_start(input logic [PC_W-1:0] m);
        start     = 1'b1;
        max_steps = m;
        tick();
        start = 1'b0;
    endtask

    task automatic do_pop();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] first_pc;
        #12;
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_pc", 64'(rd_pc), 64'd0);
        check("rst_data", 64'(rd_data), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        reset = 1'b1;
        tick();

        // Run of 5 steps, observations on steps 2 and 4
        do_start(32'd5);
        check("t1_busy", 64'(busy), 64'd1);
        do_step(1'b0, 1'b0);
        do_step(1'b1, 1'b1);
        do_step(1'b0, 1'b0);
        do_step(1'b1, 1'b0);
        check("t1_busy4", 64'(busy), 64'd1);
        do_step(1'b0, 1'b0);
        check("t1_done", 64'(done), 64'd1);
        check("t1_busy5", 64'(busy), 64'd0);
        check("t1_count", 64'(count), 64'd2);
        check("t1_pc0", 64'(rd_pc), 64'd2);
        check("t1_d0", 64'(rd_data), 64'd1);
        do_step(1'b1, 1'b1);
        check("t1_ign_done", 64'(count), 64'd2);
        do_pop();
        check("t1_pc1", 64'(rd_pc), 64'd4);
        check("t1_d1", 64'(rd_data), 64'd0);
        check("t1_count1", 64'(count), 64'd1);
        do_pop();
        check("t1_empty", 64'(rd_valid), 64'd0);

        // Six captures into a depth-4 buffer with no consumer
        do_start(32'd0);
        check("t2_busy", 64'(busy), 64'd1);
        check("t2_done", 64'(done), 64'd0);
        for (int i = 1; i <= 6; i++) begin
            do_step(1'b1, 1'(i % 2));
        end
`ifdef CONC_REC_OVERWRITE_EN
        first_pc = 64'd3;
`else
        first_pc = 64'd1;
`endif
        check("t2_count", 64'(count), 64'd4);
        check("t2_ovf", 64'(overflow), 64'd1);
        check("t2_drop", 64'(drop_cnt), 64'd2);
        for (int i = 0; i < 4; i++) begin
            check("t2_pc", 64'(rd_pc), first_pc + 64'(i));
            check("t2_data", 64'(rd_data), (first_pc + 64'(i)) & 64'd1);
            do_pop();
        end
        check("t2_empty", 64'(count), 64'd0);
        check("t2_ovf_sticky", 64'(overflow), 64'd1);
        do_flush();
        check("t2_flush_ovf", 64'(overflow), 64'd0);
        check("t2_flush_drop", 64'(drop_cnt), 64'd0);
        check("t2_flush_busy", 64'(busy), 64'd0);

        // Full buffer: capture and pop on the same edge
        do_start(32'd0);
        for (int i = 1; i <= 4; i++) begin
            do_step(1'b1, 1'b0);
        end
        check("t3_full", 64'(count), 64'd4);
        rd_ready = 1'b1;
        do_step(1'b1, 1'b1);
        rd_ready = 1'b0;
        check("t3_count", 64'(count), 64'd4);
        check("t3_ovf", 64'(overflow), 64'd0);
        check("t3_drop", 64'(drop_cnt), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("t3_pc", 64'(rd_pc), 64'd2 + 64'(i));
            do_pop();
        end
        check("t3_empty", 64'(rd_valid), 64'd0);

        // Flush together with an observed step
        step  = 1'b1;
        obs   = 1'b1;
        flush = 1'b1;
        tick();
        step  = 1'b0;
        obs   = 1'b0;
        flush = 1'b0;
        check("t4_count", 64'(count), 64'd0);
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_done", 64'(done), 64'd0);
        do_step(1'b1, 1'b1);
        check("t4_idle_step", 64'(count), 64'd0);

        // Asynchronous reset mid-run after 3 captures
        do_start(32'd0);
        for (int i = 1; i <= 3; i++) begin
            do_step(1'b1, 1'b1);
        end
        check("t5_pre", 64'(count), 64'd3);
        #2;
        reset = 1'b0;
        #1;
        check("t5_valid", 64'(rd_valid), 64'd0);
        check("t5_count", 64'(count), 64'd0);
        check("t5_pc", 64'(rd_pc), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_done", 64'(done), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        do_step(1'b1, 1'b1);
        check("t5_ignored", 64'(count), 64'd0);
        check("t5_idle", 64'(busy), 64'd0);
        do_start(32'd0);
        do_step(1'b1, 1'b1);
        check("t5_restart_pc", 64'(rd_pc), 64'd1);
        check("t5_restart_cnt", 64'(count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
